// File: rtl/cache_pkg.sv
// Shared types for the set-associative data-cache controller.
package cache_pkg;

    // Load/store operator presented by the LSU stage.
    typedef enum logic {
        LW = 1'b0,
        SW = 1'b1
    } lsu_ops;

    // Controller FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        EVICT  = 2'd2,
        REFILL = 2'd3
    } cache_state_t;

    // Line record for the baseline configuration (32-bit words, 64 sets,
    // 32-bit addresses). The controller keeps these four fields as separate
    // flop arrays so that their widths follow its own parameters.
    localparam int LINE_DATA_W = 32;
    localparam int LINE_TAG_W  = 24;

    typedef struct packed {
        logic                   valid;
        logic                   dirty;
        logic [LINE_TAG_W-1:0]  tag;
        logic [LINE_DATA_W-1:0] data;
    } line_t;

endpackage

// File: rtl/cache_lru.sv
// True-LRU bookkeeping: one age counter per way in every set.
// Age 0 is the most recently used way; the way of age WAYS-1 is the victim.
module cache_lru #(
    parameter int WAYS = 2,
    parameter int SETS = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [$clog2(SETS)-1:0]   set_idx,
    input  logic                      touch,
    input  logic [$clog2(WAYS)-1:0]   touch_way,
    output logic [$clog2(WAYS)-1:0]   victim_way
);

    localparam int WAY_W = $clog2(WAYS);

    logic [WAY_W-1:0] age [SETS][WAYS];

    // Age update: touched way becomes youngest, ways younger than it grow one older.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age[s][w] <= WAY_W'(w);
                end
            end
        end else if (touch) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == touch_way) begin
                    age[set_idx][w] <= '0;
                end else if (age[set_idx][w] < age[set_idx][touch_way]) begin
                    age[set_idx][w] <= age[set_idx][w] + WAY_W'(1);
                end
            end
        end
    end

    // Victim lookup: the single way whose age has reached WAYS-1.
    always_comb begin
        victim_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age[set_idx][w] == WAY_W'(WAYS - 1)) begin
                victim_way = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/assoc_cache_controller.sv
// N-way set-associative write-back / write-allocate data cache controller.
// One word per line; dirty victims are written back before the refill.
module assoc_cache_controller
    import cache_pkg::*;
#(
    parameter int WAYS   = 2,
    parameter int SETS   = 64,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_enable,
    input  lsu_ops            lsu_operator,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic              stall,
    output logic              resp_valid,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] write_data_int,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] dram_data_input
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam int WAY_W = $clog2(WAYS);

    cache_state_t state;

    // Captured request
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    lsu_ops            req_op;
    logic [DATA_W-1:0] req_wdata;

    // Line storage
    logic              valid_mem [SETS][WAYS];
    logic              dirty_mem [SETS][WAYS];
    logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
    logic [DATA_W-1:0] data_mem  [SETS][WAYS];

    logic [WAY_W-1:0]  vic_way;
    logic [WAY_W-1:0]  lru_victim;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  inv_way;
    logic [WAY_W-1:0]  sel_way;
    logic              hit;
    logic              inv_found;

    logic              refill_done;
    logic              fill_we;
    logic [WAY_W-1:0]  fill_way;
    logic [DATA_W-1:0] fill_data;
    logic              fill_dirty;

    logic [ADDR_W-1:0] refill_addr;
    logic [ADDR_W-1:0] evict_addr;

    // The byte offset never reaches the word-organised storage or DRAM.
    logic unused_offset;
    assign unused_offset = ^address[1:0];

    assign stall       = (state != IDLE);
    assign refill_addr = {req_tag, req_idx, 2'b00};
    assign evict_addr  = {tag_mem[req_idx][sel_way], req_idx, 2'b00};

    // Tag compare across the set plus victim choice: first invalid way, else LRU.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_mem[req_idx][w] && (tag_mem[req_idx][w] == req_tag) && !hit) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_mem[req_idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        sel_way = inv_found ? inv_way : lru_victim;
    end

    // Single line write port shared by store hits and refill completion.
    always_comb begin
        refill_done = (state == REFILL) && mem_req && mem_ready;
        fill_we     = ((state == LOOKUP) && hit && (req_op == SW)) || refill_done;
        fill_way    = (state == LOOKUP) ? hit_way : vic_way;
        fill_data   = (req_op == SW) ? req_wdata : dram_data_input;
        fill_dirty  = (req_op == SW);
    end

    cache_lru #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_lru (
        .clk        (clk),
        .rst        (rst),
        .set_idx    (req_idx),
        .touch      (((state == LOOKUP) && hit) || refill_done),
        .touch_way  (fill_way),
        .victim_way (lru_victim)
    );

    // Request capture and tag/data storage (payload only, no reset needed).
    always_ff @(posedge clk) begin
        if ((state == IDLE) && mem_enable) begin
            req_tag   <= address[ADDR_W-1:IDX_W+2];
            req_idx   <= address[IDX_W+1:2];
            req_op    <= lsu_operator;
            req_wdata <= write_data;
        end
        if (fill_we) begin
            tag_mem[req_idx][fill_way]  <= req_tag;
            data_mem[req_idx][fill_way] <= fill_data;
        end
    end

    // Valid/dirty bits: cleared by reset, set by each line write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_mem[s][w] <= 1'b0;
                    dirty_mem[s][w] <= 1'b0;
                end
            end
        end else if (fill_we) begin
            valid_mem[req_idx][fill_way] <= 1'b1;
            dirty_mem[req_idx][fill_way] <= fill_dirty;
        end
    end

    // Controller FSM with registered response and DRAM handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            vic_way        <= '0;
            resp_valid     <= 1'b0;
            read_data      <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            write_data_int <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_enable) begin
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        read_data  <= (req_op == SW) ? req_wdata : data_mem[req_idx][hit_way];
                        resp_valid <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        vic_way <= sel_way;
                        mem_req <= 1'b1;
                        if (valid_mem[req_idx][sel_way] && dirty_mem[req_idx][sel_way]) begin
                            state          <= EVICT;
                            mem_we         <= 1'b1;
                            mem_addr       <= evict_addr;
                            write_data_int <= data_mem[req_idx][sel_way];
                        end else begin
                            state    <= REFILL;
                            mem_we   <= 1'b0;
                            mem_addr <= refill_addr;
                        end
                    end
                end
                EVICT: begin
                    // Drop the request for one cycle before the refill read.
                    if (mem_req && mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= REFILL;
                    end
                end
                REFILL: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= refill_addr;
                    end else if (mem_ready) begin
                        mem_req    <= 1'b0;
                        read_data  <= fill_data;
                        resp_valid <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_assoc_cache_controller.sv
// Bench for assoc_cache_controller (WAYS=2, SETS=64): directed table,
// reset/abandon corner cases, and random traffic against a recency model.
module tb_assoc_cache_controller;
    import cache_pkg::*;

    localparam int NWAYS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_enable = 1'b0;
    lsu_ops      lsu_operator = LW;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic        stall;
    logic        resp_valid;
    logic [31:0] read_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] write_data_int;
    logic        mem_ready = 1'b0;
    logic [31:0] dram_data_input = '0;

    int n_vec = 0;
    int n_err = 0;

    assoc_cache_controller #(
        .WAYS(2), .SETS(64), .DATA_W(32), .ADDR_W(32)
    ) dut (
        .clk(clk), .rst(rst), .mem_enable(mem_enable), .lsu_operator(lsu_operator),
        .address(address), .write_data(write_data), .stall(stall),
        .resp_valid(resp_valid), .read_data(read_data), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .write_data_int(write_data_int),
        .mem_ready(mem_ready), .dram_data_input(dram_data_input)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DRAM contents and reference model ----------------
    logic [31:0] dram   [logic [31:0]];
    logic [31:0] golden [logic [31:0]];
    longint      stamp  [logic [31:0]];
    bit          dirty_m[logic [31:0]];
    longint      tnow = 0;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] dram_rd(input logic [31:0] a);
        return dram.exists(a) ? dram[a] : init_val(a);
    endfunction

    function automatic logic [31:0] gold(input logic [31:0] a);
        return golden.exists(a) ? golden[a] : init_val(a);
    endfunction

    function automatic void model_reset();
        stamp.delete();
        dirty_m.delete();
        golden = dram;
    endfunction

    // A set holds the NWAYS most recently used words; the oldest is replaced.
    function automatic void model_access(input bit op, input logic [31:0] wa, input logic [31:0] wd,
                                         output bit e_hit, output bit e_wb, output logic [31:0] e_wba,
                                         output logic [31:0] e_wbd, output logic [31:0] e_rd);
        int          cnt;
        longint      best;
        logic [31:0] victim;
        e_wb = 0; e_wba = '0; e_wbd = '0;
        tnow++;
        e_hit = stamp.exists(wa);
        if (!e_hit) begin
            cnt = 0; best = -1; victim = '0;
            foreach (stamp[k]) begin
                if (((k >> 2) & 32'h3F) == ((wa >> 2) & 32'h3F)) begin
                    cnt++;
                    if (best < 0 || stamp[k] < best) begin
                        best = stamp[k];
                        victim = k;
                    end
                end
            end
            if (cnt == NWAYS) begin
                if (dirty_m.exists(victim) && dirty_m[victim]) begin
                    e_wb = 1; e_wba = victim; e_wbd = gold(victim);
                end
                stamp.delete(victim);
                dirty_m.delete(victim);
            end
            dirty_m[wa] = 0;
        end
        stamp[wa] = tnow;
        if (op) begin
            golden[wa] = wd;
            dirty_m[wa] = 1;
        end
        e_rd = gold(wa);
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          got;
        bit          proto_err;
        logic [31:0] rd;
        int          lat;
        int          n_wr;
        int          n_rd;
        int          gap;
        int          fire_c;
        logic [31:0] wb_addr;
        logic [31:0] wb_data;
        logic [31:0] rf_addr;
    } req_res_t;

    // Issue one request and act as DRAM until the response (bounded).
    // hold=1 keeps mem_enable high with altered request fields until a
    // writeback is seen (or the response arrives).
    task automatic run_req(input bit op, input logic [31:0] addr, input logic [31:0] wd,
                           input int dly, input bit hold, output req_res_t r);
        bit          in_txn;
        int          waitc;
        bit          gap_on;
        logic [31:0] t_addr, t_wd;
        logic        t_we;
        r.got = 0; r.proto_err = 0; r.rd = '0; r.lat = 0; r.n_wr = 0; r.n_rd = 0;
        r.gap = 0; r.fire_c = 0; r.wb_addr = '0; r.wb_data = '0; r.rf_addr = '0;
        in_txn = 0; waitc = 0; gap_on = 0; t_addr = '0; t_wd = '0; t_we = 0;
        if (stall) r.proto_err = 1;
        mem_enable = 1; lsu_operator = op ? SW : LW; address = addr; write_data = wd; mem_ready = 0;
        @(posedge clk); #1;
        if (hold) begin
            address = addr ^ 32'h400; write_data = ~wd; lsu_operator = op ? LW : SW;
        end else begin
            mem_enable = 0;
        end
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk); #1;
            mem_ready = 0;
            dram_data_input = $urandom;
            if (resp_valid) begin
                r.got = 1; r.rd = read_data; r.lat = c;
                if (stall) r.proto_err = 1;
                break;
            end
            if (!stall) r.proto_err = 1;
            if (mem_req) begin
                if (!in_txn) begin
                    in_txn = 1; waitc = 0; gap_on = 0;
                    t_addr = mem_addr; t_we = mem_we; t_wd = write_data_int;
                    if (mem_we) begin
                        r.n_wr++; r.wb_addr = mem_addr; r.wb_data = write_data_int;
                    end else begin
                        r.n_rd++; r.rf_addr = mem_addr;
                    end
                end else if (mem_addr !== t_addr || mem_we !== t_we || (t_we && write_data_int !== t_wd)) begin
                    r.proto_err = 1;
                end
                if (hold && mem_we) mem_enable = 0;
                if (waitc == dly) begin
                    mem_ready = 1;
                    if (mem_we) begin
                        dram[mem_addr] = write_data_int;
                        gap_on = 1;
                    end else begin
                        dram_data_input = dram_rd(mem_addr);
                        r.fire_c = c;
                    end
                    in_txn = 0;
                end else begin
                    waitc++;
                end
            end else begin
                if (gap_on) r.gap++;
                mem_ready = 1'($urandom_range(0, 1));
            end
        end
        mem_enable = 0;
        mem_ready = 0;
    endtask

    task automatic check_res(input string tag, input req_res_t r, input bit is_lw, input logic [31:0] waddr,
                             input bit e_hit, input bit e_wb, input logic [31:0] e_wba,
                             input logic [31:0] e_wbd, input logic [31:0] e_rd);
        chk({tag, " resp"}, 32'(r.got), 32'd1);
        if (!r.got) return;
        chk({tag, " protocol"}, 32'(r.proto_err), 32'd0);
        if (e_hit) begin
            chk({tag, " hit_latency"}, r.lat, 1);
            chk({tag, " hit_dram_reqs"}, r.n_wr + r.n_rd, 0);
        end else begin
            chk({tag, " refills"}, r.n_rd, 1);
            chk({tag, " refill_addr"}, r.rf_addr, waddr);
            chk({tag, " miss_latency"}, r.lat, r.fire_c + 1);
            chk({tag, " writebacks"}, r.n_wr, 32'(e_wb));
            if (e_wb) begin
                chk({tag, " wb_addr"}, r.wb_addr, e_wba);
                chk({tag, " wb_data"}, r.wb_data, e_wbd);
                chk({tag, " wb_gap"}, r.gap, 1);
            end
        end
        if (is_lw) chk({tag, " read_data"}, r.rd, e_rd);
    endtask

    task automatic do_model_req(input string tag, input bit op, input logic [31:0] addr,
                                input logic [31:0] wd, input int dly, input bit hold);
        bit          e_hit, e_wb;
        logic [31:0] e_wba, e_wbd, e_rd, wa;
        req_res_t    r;
        wa = addr & ~32'h3;
        model_access(op, wa, wd, e_hit, e_wb, e_wba, e_wbd, e_rd);
        run_req(op, addr, wd, dly, hold, r);
        check_res(tag, r, !op, wa, e_hit, e_wb, e_wba, e_wbd, e_rd);
    endtask

    task automatic do_reset();
        rst = 0; mem_enable = 0; mem_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst_first;
        bit          op;
        logic [31:0] addr;
        logic [31:0] wd;
        int          dly;
        bit          e_hit;
        bit          e_wb;
        logic [31:0] e_wba;
        logic [31:0] e_wbd;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl [15];

    initial begin
        req_res_t r;
        bit       seen;

        tbl[0]  = '{0, 0, 32'h100, 32'h0,        3, 0, 0, 32'h0, 32'h0,        32'hDEADBEEF};
        tbl[1]  = '{0, 0, 32'h100, 32'h0,        0, 1, 0, 32'h0, 32'h0,        32'hDEADBEEF};
        tbl[2]  = '{0, 0, 32'h104, 32'h0,        1, 0, 0, 32'h0, 32'h0,        32'h5A5A0104};
        tbl[3]  = '{0, 1, 32'h104, 32'h12345678, 0, 1, 0, 32'h0, 32'h0,        32'h0};
        tbl[4]  = '{0, 0, 32'h104, 32'h0,        0, 1, 0, 32'h0, 32'h0,        32'h12345678};
        tbl[5]  = '{0, 0, 32'h000, 32'h0,        0, 0, 0, 32'h0, 32'h0,        32'h5A5A0000};
        tbl[6]  = '{0, 0, 32'h100, 32'h0,        0, 1, 0, 32'h0, 32'h0,        32'hDEADBEEF};
        tbl[7]  = '{0, 0, 32'h000, 32'h0,        0, 1, 0, 32'h0, 32'h0,        32'h5A5A0000};
        tbl[8]  = '{0, 0, 32'h200, 32'h0,        2, 0, 0, 32'h0, 32'h0,        32'h5A5A0200};
        tbl[9]  = '{0, 0, 32'h000, 32'h0,        1, 1, 0, 32'h0, 32'h0,        32'h5A5A0000};
        tbl[10] = '{1, 1, 32'h000, 32'hA5A5A5A5, 1, 0, 0, 32'h0, 32'h0,        32'h0};
        tbl[11] = '{0, 0, 32'h100, 32'h0,        0, 0, 0, 32'h0, 32'h0,        32'hDEADBEEF};
        tbl[12] = '{0, 0, 32'h200, 32'h0,        2, 0, 1, 32'h0, 32'hA5A5A5A5, 32'h5A5A0200};
        tbl[13] = '{0, 0, 32'h000, 32'h0,        1, 0, 0, 32'h0, 32'h0,        32'hA5A5A5A5};
        tbl[14] = '{0, 0, 32'h200, 32'h0,        0, 1, 0, 32'h0, 32'h0,        32'h5A5A0200};

        dram[32'h100] = 32'hDEADBEEF;

        // Reset state of every output
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset stall", 32'(stall), 0);
        chk("reset resp_valid", 32'(resp_valid), 0);
        chk("reset mem_req", 32'(mem_req), 0);
        chk("reset mem_we", 32'(mem_we), 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset write_data_int", write_data_int, 0);
        chk("reset read_data", read_data, 0);
        rst = 1;

        foreach (tbl[i]) begin
            if (tbl[i].rst_first) do_reset();
            run_req(tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].dly, 0, r);
            check_res($sformatf("vec%0d", i), r, !tbl[i].op, tbl[i].addr, tbl[i].e_hit,
                      tbl[i].e_wb, tbl[i].e_wba, tbl[i].e_wbd, tbl[i].e_rd);
        end

        // Reset while a refill is outstanding
        do_reset();
        mem_enable = 1; lsu_operator = LW; address = 32'h100; write_data = '0;
        @(posedge clk); #1;
        mem_enable = 0;
        seen = 0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(posedge clk); #1;
            seen = mem_req;
        end
        chk("abort refill_started", 32'(seen), 1);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        chk("abort mem_req", 32'(mem_req), 0);
        chk("abort stall", 32'(stall), 0);
        chk("abort resp_valid", 32'(resp_valid), 0);
        chk("abort mem_addr", mem_addr, 0);
        chk("abort read_data", read_data, 0);
        rst = 1;
        run_req(0, 32'h100, 32'h0, 1, 0, r);
        check_res("after_abort", r, 1, 32'h100, 0, 0, 32'h0, 32'h0, 32'hDEADBEEF);

        // mem_enable dropped during EVICT, request fields changing meanwhile
        do_reset();
        model_reset();
        do_model_req("drop_en sw", 1, 32'h000, 32'hA5A5A5A5, 1, 0);
        do_model_req("drop_en lw1", 0, 32'h100, 32'h0, 0, 0);
        do_model_req("drop_en lw2", 0, 32'h200, 32'h0, 2, 1);
        @(posedge clk); #1;
        chk("drop_en single_pulse", 32'(resp_valid), 0);
        chk("drop_en idle_mem_req", 32'(mem_req), 0);

        // Random traffic: 16 words crowded into 4 sets
        do_reset();
        model_reset();
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            do_model_req($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, $urandom,
                         $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/assoc_cache_controller.md
# assoc_cache_controller

Parametrised N-way set-associative, write-back/write-allocate data-cache controller with integrated tag/valid/dirty/data storage and true-LRU replacement. Sits between the pipeline LSU stage and the dummy DRAM model, replacing the direct-mapped controller. Dirty victims are written back to DRAM before the refill.

## Interface
- WAYS, 2, associativity (power of 2, ≥2)
- SETS, 64, sets per way (power of 2)
- DATA_W, 32, line = one word of DATA_W bits
- ADDR_W, 32, byte address width. Offset = address[1:0]; index = address[IDX_W+1:2] with IDX_W = $clog2(SETS); tag = remaining upper bits (TAG_W)

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, synchronous, active-low.
- mem_enable  in  1  request valid from the pipeline.
- lsu_operator  in  lsu_ops  LW or SW.
- address  in  ADDR_W  byte address.
- write_data  in  DATA_W  store data.
- stall  out  1  controller busy; the pipeline holds its request.
- resp_valid  out  1  one-cycle response pulse.
- read_data  out  DATA_W  load data; valid with resp_valid.
- mem_req  out  1  DRAM request.
- mem_we  out  1  1 = writeback, 0 = refill read.
- mem_addr  out  ADDR_W  word-aligned DRAM address.
- write_data_int  out  DATA_W  writeback data.
- mem_ready  in  1  DRAM completes the transaction in the current cycle.
- dram_data_input  in  DATA_W  refill data, valid with mem_ready.

## Operation
- States: IDLE, LOOKUP, EVICT, REFILL.
- IDLE: when mem_enable=1, capture address, operator and data; go to LOOKUP.
- LOOKUP: compare the tag in all ways of the set.
  - Hit on LW: read_data = line.
  - Hit on SW: write the line and set dirty=1; no DRAM traffic.
  - Hit (either): update LRU and go to IDLE.
- Miss, victim selection: lowest-numbered invalid way; otherwise the LRU way.
- Miss, next state: victim valid and dirty → EVICT; otherwise → REFILL.
- EVICT: mem_req=1, mem_we=1, mem_addr={victim tag, index, 2'b00}, write_data_int = victim data. Completes on the cycle mem_ready=1, then go to REFILL.
- REFILL: mem_req=1, mem_we=0, mem_addr = captured address with [1:0]=0. On mem_ready=1:
  - Victim gets valid=1 and the new tag.
  - LW: data = dram_data_input, dirty=0.
  - SW: data = write_data, dirty=1.
  - Update LRU, set read_data = line, go to IDLE.
- LRU: per-set age counters of $clog2(WAYS) bits.
  - Accessed way → 0.
  - Ways younger than its old age → +1.
  - Victim = the way with age WAYS-1.
  - Reset value: age = way index.
- After capture, mem_enable and the other request inputs are ignored until the response. Dropping mem_enable mid-miss does not abort the transaction.

## Timing
- Reset (rst=0 at a clock edge), all outputs and storage:
  - State → IDLE.
  - All valid and dirty bits → 0; LRU ages → way index.
  - stall, resp_valid, mem_req, mem_we → 0; mem_addr, write_data_int, read_data → 0.
- Reset has priority in every state. A DRAM transaction in flight is abandoned and mem_req is low on the next cycle.
- stall=1 in LOOKUP, EVICT and REFILL; stall=0 in IDLE.
- Hit latency: request accepted at edge N → resp_valid=1 in cycle N+2, with state IDLE. A new request may be accepted in that same cycle (back-to-back).
- Miss latency: resp_valid is asserted the cycle after the REFILL handshake.
- DRAM handshake:
  - mem_req, mem_we, mem_addr and write_data_int are registered and held stable until mem_ready=1.
  - mem_ready is ignored while mem_req=0.
  - mem_req is low for exactly one cycle between EVICT completion and REFILL assertion.
- resp_valid is always a single-cycle pulse; read_data holds its value until the next response.

## Structure
- cache_pkg holds:
  - lsu_ops (existing).
  - New cache_state_t enum {IDLE, LOOKUP, EVICT, REFILL}.
  - Typedef of the line record {valid, dirty, tag, data}.
- Natural sub-module: cache_lru (per-set age array; ports: set index, touch enable, touched way, victim way).
- Storage is flop arrays inside the controller, so reset invalidation needs no sweep.

## Test plan
Bench configuration: WAYS=2, SETS=64, with index = address[7:2].
1. Reset, then LW 0x100. mem_req with mem_we=0, mem_addr=0x100; mem_ready after 3 cycles with 0xDEADBEEF → resp_valid, read_data=0xDEADBEEF. Repeat LW 0x100 → resp_valid at N+2, mem_req never asserted.
2. SW 0x104 with 0x12345678 after a refill of 0x104 → hit, no mem_req. Next LW 0x104 → read_data=0x12345678.
3. LW 0x000, LW 0x100, LW 0x000, LW 0x200 → 0x200 replaces the way holding 0x100 (clean, no EVICT). LW 0x000 then hits.
4. SW 0x000 with 0xA5A5A5A5 (miss, allocate dirty), LW 0x100, LW 0x200:
   - EVICT with mem_we=1, mem_addr=0x000, write_data_int=0xA5A5A5A5.
   - One idle cycle.
   - REFILL of 0x200.
5. rst=0 during REFILL with mem_ready=0 → next cycle mem_req=0, stall=0, resp_valid=0. LW 0x100 then misses.
6. Deassert mem_enable during EVICT → writeback and refill still complete, and resp_valid pulses once.
